memory_dumper: RTL

MEMORY_DUMPER -- requirements
Module: memory_dumper

---
 rtl/memory_dumper_pkg.sv | 19 +
 rtl/memory_dumper.sv | 103 ++++++++++
 2 files changed

// File: rtl/memory_dumper_pkg.sv
// Shared definitions for the memory programmer/dumper pair: default widths
// and the dumper FSM state encoding.
package memory_dumper_pkg;

   localparam int UART_DATA_LENGTH_DEF     = 8;
   localparam int REGISTER_WIDTH_DEF       = 4;
   localparam int MEMORY_ADDRESS_WIDTH_DEF = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ_HI = 3'd1,
      CAPT_HI = 3'd2,
      READ_LO = 3'd3,
      CAPT_LO = 3'd4,
      SEND    = 3'd5,
      DONE    = 3'd6
   } dump_state_e;

endpackage : memory_dumper_pkg

// File: rtl/memory_dumper.sv
// Walks the whole memory, pairs consecutive nibbles into bytes (even address
// in the high nibble) and offers each byte to a UART transmitter with a
// valid/ready handshake. Pulses done_o once the address counter wraps.
module memory_dumper
   import memory_dumper_pkg::*;
#(
   parameter int UART_DATA_LENGTH     = UART_DATA_LENGTH_DEF,
   parameter int REGISTER_WIDTH       = REGISTER_WIDTH_DEF,
   parameter int MEMORY_ADDRESS_WIDTH = MEMORY_ADDRESS_WIDTH_DEF
) (
   input  logic                            clk_i,
   input  logic                            reset_ni,
   input  logic                            start_i,
   input  logic [REGISTER_WIDTH-1:0]       mem_data_i,
   output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
   output logic                            mem_rd_en_o,
   output logic [UART_DATA_LENGTH-1:0]     tx_data_o,
   output logic                            tx_valid_o,
   input  logic                            tx_ready_i,
   output logic                            busy_o,
   output logic                            done_o
);

   dump_state_e                     state_q;
   dump_state_e                     state_d;
   logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q;
   logic [UART_DATA_LENGTH-1:0]     data_q;

   // State register; reset is synchronous so it only takes effect on an edge.
   always_ff @(posedge clk_i) begin
      // NOTE: clocked state always uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      if (!reset_ni) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next-state logic: one pass per byte is READ_HI..SEND, then loop or finish.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = READ_HI;
         READ_HI: state_d = CAPT_HI;
         CAPT_HI: state_d = READ_LO;
         READ_LO: state_d = CAPT_LO;
         CAPT_LO: state_d = SEND;
         SEND: begin
            // The counter has already advanced past the odd address, so zero
            // here means the last word of the memory has been packed.
            if (tx_ready_i) state_d = (addr_q == '0) ? DONE : READ_HI;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address counter and byte register: cleared on start, updated on capture.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         addr_q <= '0;
         data_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) addr_q <= '0;
            end
            CAPT_HI: begin
               data_q[UART_DATA_LENGTH-1 -: REGISTER_WIDTH] <= mem_data_i;
               addr_q <= addr_q + MEMORY_ADDRESS_WIDTH'(1);
            end
            CAPT_LO: begin
               data_q[REGISTER_WIDTH-1:0] <= mem_data_i;
               addr_q <= addr_q + MEMORY_ADDRESS_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; everything is zero outside its active state.
   always_comb begin
      mem_addr_o  = '0;
      mem_rd_en_o = 1'b0;
      tx_data_o   = '0;
      tx_valid_o  = 1'b0;
      done_o      = 1'b0;
      busy_o      = (state_q != IDLE);
      unique case (state_q)
         READ_HI, READ_LO: begin
            mem_rd_en_o = 1'b1;
            mem_addr_o  = addr_q;
         end
         SEND: begin
            tx_valid_o = 1'b1;
            tx_data_o  = data_q;
         end
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

endmodule : memory_dumper
